gauss_clt: RTL and testbench
============================

GAUSS_CLT -- requirements
Module: gauss_clt

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 CK  input  1  rising-edge clock, single clock domain.
REQ-003 RB  input  1  asynchronous, active-low reset.
REQ-004 ST  input  1  synchronous init, active high, same semantics as the uniform generator's ST.
REQ-005 EN  input  1  request one noise sample; sampled only in IDLE.
REQ-006 start  input  10  uniform field from the uniform generator: first table address.
REQ-007 stride  input  10  uniform field from the uniform generator: address increment.
REQ-008 mask  input  10  uniform field from the uniform generator: XOR whitening mask.
REQ-009 noise  output  13  signed two's-complement Gaussian-approximation sample.
REQ-010 vld  output  1  noise holds a valid sample.
REQ-011 rdy  input  1  consumer accepts; transfer occurs on a rising CK edge when vld=1 and rdy=1.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACC, HOLD.
REQ-014 IDLE with EN=1 at an edge: capture start into addr, stride and mask into regs, acc=0, k=0, go to ACC.
REQ-015 IDLE with EN=0: remain in IDLE; no register changes.
REQ-016 ACC, each edge: acc += (addr XOR mask); addr = (addr + stride) mod 1024; k += 1.
REQ-017 ACC runs for exactly 4 edges (k=0..3); on the 4th edge: noise = acc_final - 2046, vld=1, go to HOLD.
REQ-018 The acc register SHALL be 12-bit unsigned (max 4 x 1023 = 4092, no overflow).
REQ-019 noise SHALL be the 13-bit two's-complement result of the subtraction, with range -2046..+2046.
REQ-020 Address arithmetic SHALL wrap modulo 1024.
REQ-021 stride=0 is legal: the same address is summed 4 times.
REQ-022 start, stride and mask changes after the capture edge SHALL be ignored until the next capture.
REQ-023 Latency: vld rises after the 5th rising edge counted from and including the capture edge.
REQ-024 HOLD with rdy=0: noise and vld held stable indefinitely; EN ignored.
REQ-025 HOLD with rdy=1: the transfer occurs; vld=0 and the state returns to IDLE on that edge; noise keeps its last value.
REQ-026 EN high at the transfer edge SHALL NOT capture; capture occurs at the next edge in IDLE.
REQ-027 Maximum throughput SHALL be one sample per 6 cycles.
REQ-028 rdy while vld=0 SHALL be ignored.
REQ-029 ST=1 at an edge (any state) SHALL take priority over EN and rdy.
REQ-030 On ST, the block SHALL go to IDLE with acc=0, addr=0, k=0, noise=0, vld=0.
REQ-031 busy SHALL be 1 in ACC and HOLD and 0 in IDLE.

Reset
REQ-032 RB=0 SHALL immediately force, regardless of CK: state IDLE, acc=0, addr=0, k=0, captured regs=0, noise=0, vld=0, busy=0.
REQ-033 RB assertion mid-ACC or mid-HOLD SHALL abort the sample; no vld pulse after release.
REQ-034 After RB release, the first capture SHALL occur at the first edge in IDLE with EN=1.

Verification
REQ-035 Case: start=0, stride=1, mask=0, EN pulse, rdy=1 -> sum 6, noise=13'h1808 (-2040), vld high one cycle, 5 edges after capture.
REQ-036 Wrap case: start=1023, stride=1, mask=0 -> addresses 1023,0,1,2, sum 1026, noise=13'h1C04 (-1020).
REQ-037 Mask and extreme values:
- start=0, stride=1, mask=10'h3FF -> noise=13'h07F8 (+2040).
- start=0, stride=0, mask=10'h3FF -> noise=13'h07FE (+2046).
- start=0, stride=0, mask=0 -> noise=13'h1802 (-2046).
REQ-038 Backpressure: rdy=0 for 10 cycles in HOLD while start/stride/mask/EN toggle -> noise and vld stable, busy=1; rdy=1 -> transfer, IDLE next edge.
REQ-039 Reset mid-operation: RB low two cycles into ACC -> all outputs 0 asynchronously; after release with EN=0, vld stays 0 for 20 cycles.
REQ-040 ST in HOLD with rdy=1 on the same edge -> ST wins, vld=0, noise=0; back-to-back EN held high -> captures spaced 6 cycles apart.

Source files
------------

// File: rtl/gauss_clt.sv
// Gaussian-approximation noise source: sums four whitened uniform table
// addresses (central limit theorem) and recentres the sum around zero.
module gauss_clt (
    input  logic        CK,
    input  logic        RB,
    input  logic        ST,
    input  logic        EN,
    input  logic [9:0]  start,
    input  logic [9:0]  stride,
    input  logic [9:0]  mask,
    input  logic        rdy,
    output logic [12:0] noise,
    output logic        vld,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [9:0]  addr_q, addr_d;
    logic [9:0]  stride_q, stride_d;
    logic [9:0]  mask_q, mask_d;
    logic [11:0] acc_q, acc_d;
    logic [1:0]  k_q, k_d;
    logic [12:0] noise_q, noise_d;
    logic        vld_q, vld_d;
    logic        busy_q, busy_d;
    logic [11:0] sum_s;

    // Midpoint of the 4 x [0,1023] sum; subtracting it centres the sample on zero.
    function automatic logic [12:0] centre(input logic [11:0] acc);
        return {1'b0, acc} - 13'd2046;
    endfunction

    // Running sum including the current whitened address.
    always_comb begin
        sum_s = acc_q + {2'b00, addr_q ^ mask_q};
    end

    // Next-state and datapath update; ST overrides every other input.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        mask_d   = mask_q;
        acc_d    = acc_q;
        k_d      = k_q;
        noise_d  = noise_q;
        vld_d    = vld_q;
        if (ST) begin
            state_d  = IDLE;
            addr_d   = 10'd0;
            stride_d = 10'd0;
            mask_d   = 10'd0;
            acc_d    = 12'd0;
            k_d      = 2'd0;
            noise_d  = 13'd0;
            vld_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (EN) begin
                        addr_d   = start;
                        stride_d = stride;
                        mask_d   = mask;
                        acc_d    = 12'd0;
                        k_d      = 2'd0;
                        state_d  = ACC;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ACC: begin
                    acc_d  = sum_s;
                    addr_d = addr_q + stride_q;
                    k_d    = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        noise_d = centre(sum_s);
                        vld_d   = 1'b1;
                        state_d = HOLD;
                    end else begin
                        state_d = ACC;
                    end
                end
                HOLD: begin
                    // noise deliberately keeps its value after the transfer
                    if (rdy) begin
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge CK or negedge RB) begin
        if (!RB) begin
            state_q  <= IDLE;
            addr_q   <= 10'd0;
            stride_q <= 10'd0;
            mask_q   <= 10'd0;
            acc_q    <= 12'd0;
            k_q      <= 2'd0;
            noise_q  <= 13'd0;
            vld_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            stride_q <= stride_d;
            mask_q   <= mask_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            noise_q  <= noise_d;
            vld_q    <= vld_d;
            busy_q   <= busy_d;
        end
    end

    assign noise = noise_q;
    assign vld   = vld_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_gauss_clt.sv
// Scoreboard bench for gauss_clt: stimulus pushes expected samples, a
// negedge monitor checks value, latency, stability and post-transfer state.
module tb_gauss_clt;

    logic        CK = 1'b0;
    logic        RB, ST, EN, rdy;
    logic [9:0]  start, stride, mask;
    logic [12:0] noise;
    logic        vld, busy;

    gauss_clt dut (
        .CK(CK), .RB(RB), .ST(ST), .EN(EN),
        .start(start), .stride(stride), .mask(mask),
        .noise(noise), .vld(vld), .rdy(rdy), .busy(busy)
    );

    always #5 CK = ~CK;

    typedef struct {
        logic [12:0] noise;
        int          cap;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          xfer_seen = 1'b0;
    bit          checked   = 1'b0;
    int          post      = 0;
    logic [12:0] held      = 13'd0;

    always @(posedge CK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain sum of four whitened addresses, recentred.
    function automatic logic [12:0] ref_noise(input int s, input int t, input int m);
        int sum = 0;
        for (int i = 0; i < 4; i++) sum += ((s + i * t) % 1024) ^ m;
        return 13'(sum - 2046);
    endfunction

    // Monitor: all DUT outputs are stable at the falling edge.
    always @(negedge CK) begin
        if (RB) begin
            if (post != 0) begin
                check("busy_after_xfer", {31'd0, busy}, 32'd0);
                check("vld_after_xfer", {31'd0, vld}, 32'd0);
                check("noise_after_xfer", {19'd0, noise}, (post == 2) ? 32'd0 : {19'd0, held});
                post = 0;
            end else if (vld) begin
                if (q.size() == 0) begin
                    check("unexpected_vld", {31'd0, vld}, 32'd0);
                end else begin
                    if (!checked) begin
                        check("noise_value", {19'd0, noise}, {19'd0, q[0].noise});
                        check("latency", cyc - q[0].cap, 32'd4);
                        held    = noise;
                        checked = 1'b1;
                    end else begin
                        check("noise_stable", {19'd0, noise}, {19'd0, held});
                    end
                    check("busy_in_hold", {31'd0, busy}, 32'd1);
                    if (rdy || ST) begin
                        void'(q.pop_front());
                        checked   = 1'b0;
                        post      = ST ? 2 : 1;
                        xfer_seen = 1'b1;
                    end
                end
            end
        end
    end

    // One sample; mode 0: rdy=1, 1: random rdy, 2: long backpressure, 3: ST kill in HOLD.
    task automatic run_txn(input logic [9:0] s, input logic [9:0] t, input logic [9:0] m,
                           input logic [12:0] exp_noise, input int mode);
        bit done = 1'b0;
        exp_t e;
        start = s; stride = t; mask = m; EN = 1'b1; rdy = 1'b0;
        @(posedge CK); #1;
        EN = 1'b0;
        e.noise = exp_noise;
        e.cap   = cyc;
        q.push_back(e);
        for (int i = 1; i <= 300; i++) begin
            start  = 10'($urandom);
            stride = 10'($urandom);
            mask   = 10'($urandom);
            EN     = 1'($urandom);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom);
                2:       rdy = (i >= 15);
                default: begin
                    rdy = (i == 7);
                    ST  = (i == 7);
                end
            endcase
            @(posedge CK); #1;
            if (xfer_seen) begin
                xfer_seen = 1'b0;
                done = 1'b1;
                break;
            end
        end
        ST = 1'b0; EN = 1'b0; rdy = 1'b0;
        check("txn_complete", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int cnt;
        int c0;
        exp_t e;
        RB = 1'b0; ST = 1'b0; EN = 1'b0; rdy = 1'b0;
        start = 10'd0; stride = 10'd0; mask = 10'd0;
        #3;
        check("rst_noise", {19'd0, noise}, 32'd0);
        check("rst_vld", {31'd0, vld}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge CK); @(posedge CK); #2;
        RB = 1'b1;
        @(posedge CK); #1;
        ST = 1'b1;
        @(posedge CK); #1;
        ST = 1'b0;
        check("st_idle_busy", {31'd0, busy}, 32'd0);

        run_txn(10'd0,    10'd1, 10'd0,     13'h1808, 0);
        run_txn(10'd1023, 10'd1, 10'd0,     13'h1C04, 0);
        run_txn(10'd0,    10'd1, 10'h3FF,   13'h07F8, 0);
        run_txn(10'd0,    10'd0, 10'h3FF,   13'h07FE, 0);
        run_txn(10'd0,    10'd0, 10'd0,     13'h1802, 0);
        run_txn(10'd517,  10'd300, 10'h155, ref_noise(517, 300, 341), 2);
        run_txn(10'd900,  10'd77,  10'h0F0, ref_noise(900, 77, 240), 3);

        // Back-to-back with EN held high: captures six cycles apart.
        start = 10'd100; stride = 10'd200; mask = 10'h2AA; EN = 1'b1; rdy = 1'b1;
        @(posedge CK); #1;
        c0 = cyc;
        for (int i = 0; i < 3; i++) begin
            e.noise = ref_noise(100, 200, 682);
            e.cap   = c0 + 6 * i;
            q.push_back(e);
        end
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 3; i++) begin
            @(posedge CK); #1;
            if (xfer_seen) begin
                xfer_seen = 1'b0;
                cnt++;
            end
        end
        EN = 1'b0; rdy = 1'b0;
        check("b2b_count", cnt, 32'd3);

        // Asynchronous reset two cycles into accumulation aborts the sample.
        start = 10'd5; stride = 10'd9; mask = 10'd0; EN = 1'b1;
        @(posedge CK); #1;
        EN = 1'b0;
        @(posedge CK); @(posedge CK); #2;
        RB = 1'b0;
        #1;
        check("arst_noise", {19'd0, noise}, 32'd0);
        check("arst_vld", {31'd0, vld}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        @(posedge CK); @(posedge CK); #2;
        RB = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge CK); #1;
            check("post_rst_vld", {31'd0, vld}, 32'd0);
        end

        for (int n = 0; n < 40; n++) begin
            logic [9:0] rs, rt, rm;
            rs = 10'($urandom); rt = 10'($urandom); rm = 10'($urandom);
            run_txn(rs, rt, rm, ref_noise(int'(rs), int'(rt), int'(rm)), (n % 5 == 0) ? 0 : 1);
        end

        repeat (5) @(posedge CK);
        #1;
        check("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
